// File: rtl/fft_frame_tx.sv
// Frames an unframed complex sample stream into 2**N_LOG2-beat Avalon-ST packets for the FFT sink.
// A one-entry output register absorbs sink_ready backpressure. Aborted frames are zero-padded to full length.
module fft_frame_tx #(
  parameter int DATA_W = 16,
  parameter int N_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     cfg_inverse,
  input  logic                     cfg_continuous,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     sink_valid,
  input  logic                     sink_ready,
  output logic [1:0]               sink_error,
  output logic                     sink_sop,
  output logic                     sink_eop,
  output logic signed [DATA_W-1:0] sink_real,
  output logic signed [DATA_W-1:0] sink_imag,
  output logic                     inverse,
  output logic                     busy,
  output logic                     aborted,
  output logic [15:0]              frames_sent
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [N_LOG2-1:0] CNT_LAST = '1;
  localparam logic [N_LOG2-1:0] CNT_ONE  = N_LOG2'(1);

  state_t                    state_q, state_d;
  logic [N_LOG2-1:0]         cnt_q, cnt_d;
  logic                      sink_valid_q, sink_valid_d;
  logic                      sop_q, sop_d;
  logic                      eop_q, eop_d;
  logic signed [DATA_W-1:0]  real_q, real_d;
  logic signed [DATA_W-1:0]  imag_q, imag_d;
  logic                      inverse_q, inverse_d;
  logic                      aborted_q, aborted_d;
  logic [15:0]               frames_q, frames_d;

  logic out_free;
  logic accept;
  logic cnt_last;

  assign out_free = ~sink_valid_q | sink_ready;
  assign in_ready = (state_q == STREAM) & out_free;
  assign accept   = in_valid & in_ready;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sink_valid_d = sink_valid_q & ~sink_ready;
    sop_d        = sop_q;
    eop_d        = eop_q;
    real_d       = real_q;
    imag_d       = imag_q;
    inverse_d    = inverse_q;
    aborted_d    = aborted_q;
    frames_d     = frames_q;

    if (sink_valid_q & sink_ready & eop_q)
      frames_d = frames_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = STREAM;
          cnt_d     = '0;
          aborted_d = 1'b0;
        end
      end

      STREAM: begin
        if (accept) begin
          sink_valid_d = 1'b1;
          sop_d        = (cnt_q == '0);
          eop_d        = cnt_last;
          real_d       = in_real;
          imag_d       = in_imag;
          cnt_d        = cnt_q + CNT_ONE;
          if (cnt_q == '0)
            inverse_d = cfg_inverse;
          if (cnt_last && !cfg_continuous)
            state_d = IDLE;
        end
        // An abort coinciding with the eop beat is moot: the frame already completed.
        if (abort && !(accept && cnt_last)) begin
          if (cnt_d == '0) begin
            state_d = IDLE;
          end else begin
            state_d   = FLUSH;
            aborted_d = 1'b1;
          end
        end
      end

      FLUSH: begin
        if (out_free) begin
          sink_valid_d = 1'b1;
          sop_d        = 1'b0;
          eop_d        = cnt_last;
          real_d       = '0;
          imag_d       = '0;
          cnt_d        = cnt_q + CNT_ONE;
          if (cnt_last)
            state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sink_valid_q <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      real_q       <= '0;
      imag_q       <= '0;
      inverse_q    <= 1'b0;
      aborted_q    <= 1'b0;
      frames_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sink_valid_q <= sink_valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      real_q       <= real_d;
      imag_q       <= imag_d;
      inverse_q    <= inverse_d;
      aborted_q    <= aborted_d;
      frames_q     <= frames_d;
    end
  end

  assign sink_valid  = sink_valid_q;
  assign sink_error  = 2'b00;
  assign sink_sop    = sop_q;
  assign sink_eop    = eop_q;
  assign sink_real   = real_q;
  assign sink_imag   = imag_q;
  assign inverse     = inverse_q;
  assign busy        = (state_q != IDLE) | sink_valid_q;
  assign aborted     = aborted_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fft_frame_tx.sv
// Directed bench for fft_frame_tx with 8-point frames: framing, continuous mode, stalls, abort padding, reset.
module tb_fft_frame_tx;

  localparam int DATA_W = 16;
  localparam int N_LOG2 = 3;
  localparam int FRAME  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, abort, cfg_inverse, cfg_continuous;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_real, in_imag;
  logic              sink_valid, sink_ready, sink_sop, sink_eop;
  logic [1:0]        sink_error;
  logic [DATA_W-1:0] sink_real, sink_imag;
  logic              inverse, busy, aborted;
  logic [15:0]       frames_sent;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  fft_frame_tx #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_inverse(cfg_inverse), .cfg_continuous(cfg_continuous),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .inverse(inverse), .busy(busy), .aborted(aborted), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] bw(input logic sop, input logic eop, input logic inv,
                                     input logic [15:0] re, input logic [15:0] im);
    return {29'd0, sop, eop, inv, re, im};
  endfunction

  // Monitor: records accepted beats and checks that stalled outputs hold.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_word  = '0;
  always @(negedge clk) begin
    logic [63:0] w;
    w = bw(sink_sop, sink_eop, inverse, sink_real, sink_imag);
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(sink_valid), 64'd1);
        chk("stall_hold", w, prev_word);
      end
      if (sink_valid && sink_ready) got_q.push_back(w);
      prev_stall = sink_valid & ~sink_ready;
      prev_word  = w;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  // Drives samples base+1..base+n; inverse toggles per 8-sample frame when tog is set.
  task automatic drive(input int n, input int base, input bit rnd, input bit cont,
                       input bit tog, input bit inv);
    int idx = 0;
    int cyc = 0;
    logic acc;
    logic [15:0] v;
    while (idx < n && cyc < 2000) begin
      v              = 16'(base + idx + 1);
      in_valid       = 1'b1;
      in_real        = v;
      in_imag        = 16'd0 - v;
      cfg_inverse    = tog ? 1'((idx / FRAME) % 2) : inv;
      cfg_continuous = cont && (idx != n - 1);
      sink_ready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("drive_budget", 64'(idx), 64'(n));
  endtask

  task automatic drain(input bit rnd);
    int cyc = 0;
    while (busy && cyc < 400) begin
      sink_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    sink_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  task automatic expect_data(input int n, input int base, input bit tog, input bit inv);
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      v = 16'(base + i + 1);
      exp_q.push_back(bw(i % FRAME == 0, i % FRAME == FRAME - 1,
                         tog ? 1'((i / FRAME) % 2) : inv, v, 16'd0 - v));
    end
  endtask

  task automatic cmp_beats(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(sink_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_aborted"}, 64'(aborted), 64'd0);
    chk({tag, "_frames"}, 64'(frames_sent), 64'd0);
    chk({tag, "_beat"}, bw(sink_sop, sink_eop, inverse, sink_real, sink_imag), 64'd0);
    chk({tag, "_error"}, 64'(sink_error), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_inverse = 1'b0; cfg_continuous = 1'b0;
    in_valid = 1'b0; in_real = '0; in_imag = '0; sink_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, no backpressure
    pulse_start();
    drive(8, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(1'b0);
    expect_data(8, 0, 1'b0, 1'b0);
    cmp_beats("single");
    exp_frames += 1;
    chk("single_frames", 64'(frames_sent), 64'(exp_frames));
    chk("single_in_ready", 64'(in_ready), 64'd0);

    // Continuous mode, inverse toggles per frame
    pulse_start();
    drive(24, 10, 1'b0, 1'b1, 1'b1, 1'b0);
    drain(1'b0);
    expect_data(24, 10, 1'b1, 1'b0);
    cmp_beats("cont");
    exp_frames += 3;
    chk("cont_frames", 64'(frames_sent), 64'(exp_frames));

    // Same traffic under random backpressure
    pulse_start();
    drive(16, 50, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(1'b1);
    expect_data(16, 50, 1'b1, 1'b0);
    cmp_beats("stall");
    exp_frames += 2;
    chk("stall_frames", 64'(frames_sent), 64'(exp_frames));

    // Abort after third beat: remaining five beats are zero padding
    pulse_start();
    drive(3, 100, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_abort();
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_aborted", 64'(aborted), 64'd1);
    @(posedge clk); #1;
    drain(1'b0);
    expect_data(3, 100, 1'b0, 1'b1);
    for (int i = 3; i < FRAME; i++)
      exp_q.push_back(bw(1'b0, i == FRAME - 1, 1'b1, 16'd0, 16'd0));
    cmp_beats("abort");
    exp_frames += 1;
    chk("abort_frames", 64'(frames_sent), 64'(exp_frames));
    chk("abort_sticky", 64'(aborted), 64'd1);

    // Abort before first beat: back to IDLE, nothing emitted
    pulse_start();
    chk("start_clears_aborted", 64'(aborted), 64'd0);
    pulse_abort();
    in_valid = 1'b1; in_real = 16'd7; in_imag = 16'd7;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("early_abort_busy", 64'(busy), 64'd0);
    chk("early_abort_aborted", 64'(aborted), 64'd0);
    cmp_beats("early_abort");

    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_wins_busy", 64'(busy), 64'd1);
    chk("start_wins_in_ready", 64'(in_ready), 64'd1);

    // Reset mid-frame
    drive(3, 200, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    got_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
